// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
package hazard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending bits for long-latency writers, with a 3-port
// combinational lookup (rs1, rs2, rd). Register x0 is never tracked.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = REG_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en,
    input  logic [ADDR_W-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    input  logic [ADDR_W-1:0]   rs1_addr,
    input  logic [ADDR_W-1:0]   rs2_addr,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rs1_hit,
    output logic                rs2_hit,
    output logic                rd_hit,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // NOTE: the default copy of pending_q first keeps every path assigned, so no latch is inferred.
    always_comb begin
        pending_d = pending_q;
        if (clr_en && (clr_addr != ADDR_W'(X0))) begin
            pending_d[clr_addr] = 1'b0;
        end
        // Applied after the clear so a same-cycle set to the same register wins.
        if (set_en && (set_addr != ADDR_W'(X0))) begin
            pending_d[set_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only; these are plain flops, so every bit is reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rs1_hit = pending_q[rs1_addr];
    assign rs2_hit = pending_q[rs2_addr];
    assign rd_hit  = pending_q[rd_addr];
    assign pending = pending_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Issue/stall/flush controller beside id_stage: scoreboard hazards plus a taken-branch
// flush sequencer. Define HAZARD_PERF_EN to add stall/flush cycle counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned ADDR_W       = REG_ADDR_W,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [ADDR_W-1:0]   id_rs1,
    input  logic [ADDR_W-1:0]   id_rs2,
    input  logic [ADDR_W-1:0]   id_rd,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic                id_writes_rd,
    input  logic                id_long,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_rd,
    input  logic                branch_taken,
    output logic                issue,
    output logic                stall_if,
    output logic                stall_id,
    output logic                flush_id,
    output logic                flush_ex,
    output logic [NUM_REGS-1:0] busy_mask
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_flush_cycles
`endif
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             rs1_hit, rs2_hit, rd_hit;
    logic             hazard;
    logic             stall;

    hazard_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue & id_long & id_writes_rd),
        .set_addr (id_rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_rd),
        .rs1_addr (id_rs1),
        .rs2_addr (id_rs2),
        .rd_addr  (id_rd),
        .rs1_hit  (rs1_hit),
        .rs2_hit  (rs2_hit),
        .rd_hit   (rd_hit),
        .pending  (busy_mask)
    );

    assign hazard = id_valid & ((id_uses_rs1 & rs1_hit) |
                                (id_uses_rs2 & rs2_hit) |
                                (id_writes_rd & rd_hit));

    // Everything is forced quiet while reset is held, independent of stale state.
    assign flush_id = !reset & (branch_taken | (state_q == ST_FLUSH));
    assign stall    = !reset & hazard & !flush_id;
    assign stall_if = stall;
    assign stall_id = stall;
    assign flush_ex = !reset & (branch_taken | stall);
    assign issue    = !reset & id_valid & !hazard & !flush_id;

    // A branch in RUN or FLUSH (re)loads the counter; FLUSH_CYCLES=1 never leaves RUN.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (branch_taken) begin
            if (FLUSH_CYCLES > 1) begin
                state_d     = ST_FLUSH;
                flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
            end
        end else if (state_q == ST_FLUSH) begin
            flush_cnt_d = flush_cnt_q - CNT_W'(1);
            if (flush_cnt_q == CNT_W'(1)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, stall_id};
        perf_flush_d = perf_flush_q + {31'd0, flush_id};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_cycles = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (default FLUSH_CYCLES=2).
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2, id_writes_rd, id_long;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        branch_taken;
    logic        issue, stall_if, stall_id, flush_id, flush_ex;
    logic [31:0] busy_mask;
    logic [4:0]  outs;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_cycles;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    // {issue, stall_if, stall_id, flush_id, flush_ex}
    assign outs = {issue, stall_if, stall_id, flush_id, flush_ex};

    hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_writes_rd (id_writes_rd),
        .id_long      (id_long),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .branch_taken (branch_taken),
        .issue        (issue),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .flush_id     (flush_id),
        .flush_ex     (flush_ex),
        .busy_mask    (busy_mask)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_cycles (perf_flush_cycles)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_writes_rd = 0; id_long = 0;
        wb_valid = 0; wb_rd = 0; branch_taken = 0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic wr, input logic lng);
        id_valid = 1; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
        id_rd = rd; id_writes_rd = wr; id_long = lng;
    endtask

    task automatic test_reset();
        reset = 1;
        set_idle();
        set_id(5'd1, 1, 5'd2, 1, 5'd3, 1, 1);
        branch_taken = 1;
        @(negedge clk);
        n_cmp++;
        if (outs !== 5'b00000) begin
            n_mis++; $display("FAIL reset_outs got=%b want=%b", outs, 5'b00000);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (busy_mask !== 32'h0) begin
            n_mis++; $display("FAIL reset_busy got=%h want=%h", busy_mask, 32'h0);
        end
        tick();
        reset = 0;
        set_idle();
        tick();
    endtask

    task automatic test_basic_issue();
        set_id(5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
        @(negedge clk);
        n_cmp++;
        if (outs !== 5'b10000) begin
            n_mis++; $display("FAIL basic_issue got=%b want=%b", outs, 5'b10000);
        end
        tick();
        set_idle();
        n_cmp++;
        if (busy_mask !== 32'h0) begin
            n_mis++; $display("FAIL basic_busy got=%h want=%h", busy_mask, 32'h0);
        end
    endtask

    task automatic test_raw_stall();
        set_id(5'd2, 1, 5'd0, 0, 5'd1, 1, 1);   // lw x1
        @(negedge clk);
        n_cmp++;
        if (outs !== 5'b10000) begin
            n_mis++; $display("FAIL raw_long_issue got=%b want=%b", outs, 5'b10000);
        end
        tick();
        n_cmp++;
        if (busy_mask !== 32'h0000_0002) begin
            n_mis++; $display("FAIL raw_busy_set got=%h want=%h", busy_mask, 32'h2);
        end
        set_id(5'd1, 1, 5'd2, 1, 5'd3, 1, 0);   // add x3,x1,x2
        @(negedge clk);
        n_cmp++;
        if (outs !== 5'b01101) begin
            n_mis++; $display("FAIL raw_stall got=%b want=%b", outs, 5'b01101);
        end
        tick();
        wb_valid = 1; wb_rd = 5'd1;
        @(negedge clk);
        n_cmp++;
        if (outs !== 5'b01101) begin
            n_mis++; $display("FAIL raw_no_bypass got=%b want=%b", outs, 5'b01101);
        end
        tick();
        wb_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (outs !== 5'b10000 || busy_mask !== 32'h0) begin
            n_mis++; $display("FAIL raw_release got=%b/%h want=%b/%h", outs, busy_mask, 5'b10000, 32'h0);
        end
        tick();
        set_idle();
    endtask

    task automatic test_x0_and_waw();
        set_id(5'd2, 1, 5'd0, 0, 5'd0, 1, 1);   // long op to x0
        tick();
        n_cmp++;
        if (busy_mask !== 32'h0) begin
            n_mis++; $display("FAIL x0_busy got=%h want=%h", busy_mask, 32'h0);
        end
        set_id(5'd0, 1, 5'd0, 1, 5'd3, 1, 0);
        @(negedge clk);
        n_cmp++;
        if (outs !== 5'b10000) begin
            n_mis++; $display("FAIL x0_consumer got=%b want=%b", outs, 5'b10000);
        end
        tick();
        set_id(5'd0, 0, 5'd0, 0, 5'd4, 1, 1);   // long op to x4
        tick();
        set_id(5'd0, 0, 5'd0, 0, 5'd4, 1, 0);   // writes x4 again, reads nothing
        @(negedge clk);
        n_cmp++;
        if (outs !== 5'b01101) begin
            n_mis++; $display("FAIL waw_stall got=%b want=%b", outs, 5'b01101);
        end
        wb_valid = 1; wb_rd = 5'd4;
        tick();
        wb_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (outs !== 5'b10000) begin
            n_mis++; $display("FAIL waw_release got=%b want=%b", outs, 5'b10000);
        end
        tick();
        set_idle();
    endtask

    task automatic test_set_clear_same();
        set_id(5'd6, 1, 5'd0, 0, 5'd5, 1, 1);
        wb_valid = 1; wb_rd = 5'd5;
        @(negedge clk);
        n_cmp++;
        if (outs !== 5'b10000) begin
            n_mis++; $display("FAIL setclr_issue got=%b want=%b", outs, 5'b10000);
        end
        tick();
        set_idle();
        n_cmp++;
        if (busy_mask !== 32'h0000_0020) begin
            n_mis++; $display("FAIL setclr_set_wins got=%h want=%h", busy_mask, 32'h20);
        end
        wb_valid = 1; wb_rd = 5'd5;
        tick();
        wb_valid = 0;
        n_cmp++;
        if (busy_mask !== 32'h0) begin
            n_mis++; $display("FAIL setclr_clear got=%h want=%h", busy_mask, 32'h0);
        end
    endtask

    task automatic test_branch_flush();
        logic [4:0] exp_seq[6];
        exp_seq = '{5'b00011, 5'b00010, 5'b01101, 5'b00011, 5'b00011, 5'b00010};
        set_id(5'd2, 1, 5'd0, 0, 5'd1, 1, 1);   // long op to x1
        tick();
        set_id(5'd1, 1, 5'd2, 1, 5'd3, 1, 0);   // consumer held on x1
        for (int i = 0; i < 6; i++) begin
            branch_taken = (i == 0 || i == 3 || i == 4);
            @(negedge clk);
            n_cmp++;
            if (outs !== exp_seq[i]) begin
                n_mis++; $display("FAIL branch_seq[%0d] got=%b want=%b", i, outs, exp_seq[i]);
            end
            tick();
        end
        branch_taken = 0;
        @(negedge clk);
        n_cmp++;
        if (outs !== 5'b01101) begin
            n_mis++; $display("FAIL branch_back_to_run got=%b want=%b", outs, 5'b01101);
        end
        set_idle();
        wb_valid = 1; wb_rd = 5'd1;
        tick();
        set_idle();
    endtask

    task automatic test_mid_reset();
        set_id(5'd0, 0, 5'd0, 0, 5'd7, 1, 1);   // long op to x7
        tick();
        n_cmp++;
        if (busy_mask !== 32'h0000_0080) begin
            n_mis++; $display("FAIL mreset_busy_set got=%h want=%h", busy_mask, 32'h80);
        end
        set_idle();
        branch_taken = 1;
        tick();
        branch_taken = 0;
        reset = 1;                            // FSM now in FLUSH
        @(negedge clk);
        n_cmp++;
        if (outs !== 5'b00000) begin
            n_mis++; $display("FAIL mreset_quiet got=%b want=%b", outs, 5'b00000);
        end
        tick();
        reset = 0;
        @(negedge clk);
        n_cmp++;
        if (outs !== 5'b00000 || busy_mask !== 32'h0) begin
            n_mis++; $display("FAIL mreset_cleared got=%b/%h want=%b/%h", outs, busy_mask, 5'b00000, 32'h0);
        end
        wb_valid = 1; wb_rd = 5'd7;           // late retire after reset
        tick();
        set_idle();
        n_cmp++;
        if (busy_mask !== 32'h0) begin
            n_mis++; $display("FAIL mreset_late_wb got=%h want=%h", busy_mask, 32'h0);
        end
`ifdef HAZARD_PERF_EN
        set_id(5'd0, 0, 5'd0, 0, 5'd9, 1, 1);
        tick();
        set_id(5'd9, 1, 5'd0, 0, 5'd10, 1, 0);
        tick(); tick(); tick();
        set_idle();
        n_cmp++;
        if (perf_stall_cycles !== 32'd3) begin
            n_mis++; $display("FAIL perf_stall got=%0d want=%0d", perf_stall_cycles, 3);
        end
`endif
    endtask

    initial begin
        set_idle();
        test_reset();
        test_basic_issue();
        test_raw_stall();
        test_x0_and_waw();
        test_set_clear_same();
        test_branch_flush();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
